// File: rtl/multicycle_cpu_pkg.sv
// Shared types for the multi-cycle RV32I-subset core: ALU operations, FSM
// states and the instruction-field encodings it decodes.
package cpu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SLT
    } alu_op_t;

    // One-hot so a corrupted state is detectable and falls into HALT.
    typedef enum logic [4:0] {
        S_FETCH     = 5'b00001,
        S_DECODE    = 5'b00010,
        S_EXECUTE   = 5'b00100,
        S_WRITEBACK = 5'b01000,
        S_HALT      = 5'b10000
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/multicycle_cpu_if.sv
// Bundle of preload inputs, stall control and architectural status outputs
// between the core and its environment.
interface multicycle_cpu_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned IMEM_DEPTH = 32
);
    logic            step_en;
    logic [31:0]     initial_instructions    [IMEM_DEPTH];
    logic [XLEN-1:0] initial_register_values [NUM_REGS];
    logic [XLEN-1:0] pc_out;
    logic [31:0]     instruction_out;
    logic            halted;
    logic            retire;
    logic [31:0]     retired_count;
    logic [XLEN-1:0] register_check          [NUM_REGS];

    modport master (
        output step_en, initial_instructions, initial_register_values,
        input  pc_out, instruction_out, halted, retire, retired_count, register_check
    );

    modport slave (
        input  step_en, initial_instructions, initial_register_values,
        output pc_out, instruction_out, halted, retire, retired_count, register_check
    );
endinterface

// File: rtl/multicycle_cpu_alu.sv
// Parametrised-width combinational ALU; arithmetic wraps modulo 2^XLEN.
import cpu_pkg::*;

module alu_n #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  alu_op_t         op_i,
    output logic [XLEN-1:0] y_o
);
    localparam int unsigned SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    assign shamt = b_i[SHW-1:0];

    always_comb begin
        y_o = '0;
        case (op_i)
            ALU_ADD: y_o = a_i + b_i;
            ALU_SUB: y_o = a_i - b_i;
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            ALU_XOR: y_o = a_i ^ b_i;
            ALU_SLL: y_o = a_i << shamt;
            ALU_SRL: y_o = a_i >> shamt;
            ALU_SLT: y_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            default: y_o = '0;
        endcase
    end
endmodule

// File: rtl/multicycle_cpu.sv
// Four-clock FETCH/DECODE/EXECUTE/WRITEBACK RV32I-subset core with stall,
// hardwired x0, halt on illegal instructions and a retired-instruction counter.
import cpu_pkg::*;

module multicycle_cpu #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned IMEM_DEPTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    multicycle_cpu_if.slave  bus
);
    localparam int unsigned RIDX = $clog2(NUM_REGS);
    localparam int unsigned IIDX = $clog2(IMEM_DEPTH);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic            reg_we;

    logic [6:0] opcode, f7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign f3     = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign f7     = ir_q[31:25];

    function automatic logic reg_ok(input logic [4:0] r);
        return 32'(r) < NUM_REGS;
    endfunction

    logic    legal, use_imm;
    alu_op_t alu_op;

    always_comb begin
        legal   = 1'b0;
        use_imm = 1'b0;
        alu_op  = ALU_ADD;
        case (opcode)
            OP_R: begin
                legal = 1'b1;
                case ({f7, f3})
                    {F7_BASE, F3_ADD}: alu_op = ALU_ADD;
                    {F7_ALT,  F3_ADD}: alu_op = ALU_SUB;
                    {F7_BASE, F3_AND}: alu_op = ALU_AND;
                    {F7_BASE, F3_OR }: alu_op = ALU_OR;
                    {F7_BASE, F3_XOR}: alu_op = ALU_XOR;
                    {F7_BASE, F3_SLL}: alu_op = ALU_SLL;
                    {F7_BASE, F3_SRL}: alu_op = ALU_SRL;
                    {F7_BASE, F3_SLT}: alu_op = ALU_SLT;
                    default:           legal  = 1'b0;
                endcase
                if (!reg_ok(rs2)) legal = 1'b0;
            end
            OP_I: begin
                legal   = 1'b1;
                use_imm = 1'b1;
                case (f3)
                    F3_ADD:  alu_op = ALU_ADD;
                    F3_AND:  alu_op = ALU_AND;
                    F3_OR:   alu_op = ALU_OR;
                    F3_XOR:  alu_op = ALU_XOR;
                    F3_SLT:  alu_op = ALU_SLT;
                    default: legal  = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
        if (!reg_ok(rd) || !reg_ok(rs1)) legal = 1'b0;
    end

    logic [XLEN-1:0] alu_y;

    alu_n #(.XLEN(XLEN)) u_alu (
        .a_i  (a_q),
        .b_i  (use_imm ? imm_q : b_q),
        .op_i (alu_op),
        .y_o  (alu_y)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        imm_d   = imm_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        reg_we  = 1'b0;
        if (bus.step_en) begin
            case (state_q)
                S_FETCH: begin
                    ir_d    = bus.initial_instructions[pc_q[IIDX+1:2]];
                    state_d = S_DECODE;
                end
                S_DECODE: begin
                    if (legal) begin
                        a_d     = regs_q[rs1[RIDX-1:0]];
                        b_d     = regs_q[rs2[RIDX-1:0]];
                        imm_d   = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
                        state_d = S_EXECUTE;
                    end else begin
                        state_d = S_HALT;
                    end
                end
                S_EXECUTE: begin
                    res_d   = alu_y;
                    state_d = S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    reg_we  = (rd != 5'd0);
                    pc_d    = pc_q + XLEN'(4);
                    cnt_d   = cnt_q + 32'd1;
                    state_d = S_FETCH;
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_HALT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= bus.initial_register_values[i];
            end
            regs_q[0] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            if (reg_we) regs_q[rd[RIDX-1:0]] <= res_q;
        end
    end

    always_comb begin
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            bus.register_check[i] = regs_q[i];
        end
        bus.register_check[0] = '0;
    end

    assign bus.pc_out          = pc_q;
    assign bus.instruction_out = ir_q;
    assign bus.halted          = (state_q == S_HALT);
    assign bus.retire          = (state_q == S_WRITEBACK) && bus.step_en;
    assign bus.retired_count   = cnt_q;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed self-checking bench for multicycle_cpu: a 32-bit core for the main
// scenarios and a 16-bit / 8-register core for width and index corners.
module tb_multicycle_cpu;

    logic clk = 1'b0;
    logic rst32 = 1'b1;
    logic rst16 = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   retire_seen;

    always #5 clk = ~clk;

    multicycle_cpu_if #(.XLEN(32), .NUM_REGS(32), .IMEM_DEPTH(32)) if32 ();
    multicycle_cpu_if #(.XLEN(16), .NUM_REGS(8),  .IMEM_DEPTH(32)) if16 ();

    multicycle_cpu #(.XLEN(32), .NUM_REGS(32), .IMEM_DEPTH(32)) dut32 (
        .clk   (clk),
        .reset (rst32),
        .bus   (if32.slave)
    );

    multicycle_cpu #(.XLEN(16), .NUM_REGS(8), .IMEM_DEPTH(32)) dut16 (
        .clk   (clk),
        .reset (rst16),
        .bus   (if16.slave)
    );

    typedef struct {
        logic [31:0] instr;
        int unsigned rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [17];
    logic [31:0] exp_regs [32];

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (if32.retire === 1'b1) retire_seen++;
        end
    endtask

    task automatic reset32();
        rst32 = 1'b1;
        @(posedge clk);
        #1;
        rst32 = 1'b0;
        retire_seen = 0;
    endtask

    task automatic load_prog1();
        for (int i = 0; i < 32; i++) if32.initial_instructions[i] = 32'h0;
        if32.initial_instructions[0] = enc_r(7'b0000000, 5'd5, 5'd6, 3'b000, 5'd7);
        if32.initial_instructions[1] = enc_r(7'b0100000, 5'd8, 5'd9, 3'b000, 5'd10);
        if32.initial_instructions[2] = enc_i(12'd1, 5'd12, 3'b000, 5'd13);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{enc_i(12'd5,   5'd1,  3'b000, 5'd0),  0,  32'd0};
        vecs[1]  = '{enc_i(12'hFFF, 5'd0,  3'b010, 5'd2),  2,  32'd0};
        vecs[2]  = '{enc_r(7'h00, 5'd1,  5'd2,  3'b000, 5'd3) | 32'h4000_0000, 3, 32'hFFFFF447};
        vecs[3]  = '{enc_r(7'h00, 5'd0,  5'd3,  3'b010, 5'd4),  4,  32'd1};
        vecs[4]  = '{enc_r(7'h00, 5'd3,  5'd0,  3'b010, 5'd5),  5,  32'd0};
        vecs[5]  = '{enc_r(7'h00, 5'd13, 5'd10, 3'b111, 5'd6),  6,  32'd3008};
        vecs[6]  = '{enc_r(7'h00, 5'd13, 5'd10, 3'b110, 5'd7),  7,  32'd3015};
        vecs[7]  = '{enc_r(7'h00, 5'd13, 5'd10, 3'b100, 5'd8),  8,  32'd7};
        vecs[8]  = '{enc_r(7'h00, 5'd1,  5'd11, 3'b001, 5'd9),  9,  32'h86000000};
        vecs[9]  = '{enc_r(7'h00, 5'd14, 5'd3,  3'b101, 5'd11), 11, 32'h03FFFFD1};
        vecs[10] = '{enc_i(12'h0F0, 5'd13, 3'b111, 5'd12), 12, 32'd192};
        vecs[11] = '{enc_i(12'hFF0, 5'd15, 3'b110, 5'd15), 15, 32'hFFFFFFF7};
        vecs[12] = '{enc_i(12'hFFF, 5'd16, 3'b100, 5'd16), 16, 32'hFFFFF437};
        vecs[13] = '{enc_r(7'h00, 5'd1,  5'd3,  3'b000, 5'd17), 17, 32'd0};
        vecs[14] = '{enc_i(12'h7FF, 5'd18, 3'b000, 5'd18), 18, 32'd5065};
        vecs[15] = '{enc_i(12'h800, 5'd3,  3'b010, 5'd19), 19, 32'd1};
        vecs[16] = '{enc_r(7'h20, 5'd21, 5'd1,  3'b000, 5'd20), 20, 32'hFFFFFFEC};

        if32.step_en = 1'b1;
        for (int i = 0; i < 32; i++) if32.initial_register_values[i] = 32'(3000 + i);
        load_prog1();

        if16.step_en = 1'b1;
        for (int i = 0; i < 8; i++) if16.initial_register_values[i] = 16'(i);
        if16.initial_register_values[5] = 16'd17;
        for (int i = 0; i < 32; i++) if16.initial_instructions[i] = 32'h0;
        if16.initial_instructions[0] = enc_i(12'h800, 5'd1, 3'b000, 5'd3);
        if16.initial_instructions[1] = enc_r(7'h00, 5'd5, 5'd1, 3'b001, 5'd4);
        if16.initial_instructions[2] = enc_r(7'h00, 5'd1, 5'd3, 3'b010, 5'd6);
        if16.initial_instructions[3] = enc_i(12'h000, 5'd1, 3'b000, 5'd9);

        // Basic run
        reset32();
        check("rst_pc", if32.pc_out, 0);
        check("rst_ir", if32.instruction_out, 0);
        check("rst_halted", if32.halted, 0);
        check("rst_retire", if32.retire, 0);
        check("rst_count", if32.retired_count, 0);
        check("rst_x0", if32.register_check[0], 0);
        check("rst_x5", if32.register_check[5], 3005);
        step(4);
        check("run1_x7", if32.register_check[7], 6011);
        check("run1_pc", if32.pc_out, 4);
        check("run1_count", if32.retired_count, 1);
        check("run1_retire_once", retire_seen, 1);
        step(8);
        check("run3_x10", if32.register_check[10], 1);
        check("run3_x13", if32.register_check[13], 3013);
        check("run3_pc", if32.pc_out, 12);
        check("run3_count", if32.retired_count, 3);

        // Halt on the zero word
        step(1);
        check("halt_e13", if32.halted, 0);
        step(1);
        check("halt_e14", if32.halted, 1);
        check("halt_pc", if32.pc_out, 12);
        retire_seen = 0;
        step(20);
        check("halt_retire", retire_seen, 0);
        check("halt_count", if32.retired_count, 3);
        check("halt_pc2", if32.pc_out, 12);
        for (int i = 0; i < 32; i++) exp_regs[i] = 32'(3000 + i);
        exp_regs[0] = 0; exp_regs[7] = 6011; exp_regs[10] = 1; exp_regs[13] = 3013;
        for (int i = 0; i < 32; i++) check($sformatf("halt_x%0d", i), if32.register_check[i], exp_regs[i]);

        // Stall in EXECUTE of the add
        reset32();
        step(2);
        if32.step_en = 1'b0;
        step(5);
        check("stall_pc", if32.pc_out, 0);
        check("stall_x7", if32.register_check[7], 3007);
        check("stall_count", if32.retired_count, 0);
        check("stall_retire", retire_seen, 0);
        check("stall_ir", if32.instruction_out, enc_r(7'b0000000, 5'd5, 5'd6, 3'b000, 5'd7));
        if32.step_en = 1'b1;
        step(1);
        check("unstall_retire", if32.retire, 1);
        check("unstall_x7_early", if32.register_check[7], 3007);
        step(1);
        check("unstall_x7", if32.register_check[7], 6011);
        check("unstall_retire_off", if32.retire, 0);
        check("unstall_count", if32.retired_count, 1);
        check("unstall_retire_once", retire_seen, 1);

        // Asynchronous reset during EXECUTE of the sub
        step(2);
        #3;
        rst32 = 1'b1;
        #1;
        check("areset_pc", if32.pc_out, 0);
        check("areset_x7", if32.register_check[7], 3007);
        check("areset_x10", if32.register_check[10], 3010);
        check("areset_count", if32.retired_count, 0);
        check("areset_ir", if32.instruction_out, 0);
        @(posedge clk);
        #1;
        rst32 = 1'b0;
        retire_seen = 0;
        step(12);
        check("rerun_x7", if32.register_check[7], 6011);
        check("rerun_x10", if32.register_check[10], 1);
        check("rerun_x13", if32.register_check[13], 3013);
        check("rerun_pc", if32.pc_out, 12);
        check("rerun_count", if32.retired_count, 3);

        // Table-driven x0 / signed / logic / shift program
        for (int i = 0; i < 32; i++) if32.initial_instructions[i] = 32'h0;
        for (int i = 0; i < 17; i++) if32.initial_instructions[i] = vecs[i].instr;
        reset32();
        for (int k = 0; k < 17; k++) begin
            step(4);
            check($sformatf("vec%0d_x%0d", k, vecs[k].rd), if32.register_check[vecs[k].rd], vecs[k].exp);
            check($sformatf("vec%0d_count", k), if32.retired_count, 32'(k + 1));
        end
        step(2);
        check("vec_end_halted", if32.halted, 1);
        check("vec_end_pc", if32.pc_out, 68);

        // 16-bit core with 8 registers
        @(posedge clk);
        #1;
        rst16 = 1'b0;
        step(4);
        check("x16_addi_x3", if16.register_check[3], 16'hF801);
        step(4);
        check("x16_sll_x4", if16.register_check[4], 2);
        step(4);
        check("x16_slt_x6", if16.register_check[6], 1);
        step(2);
        check("x16_rd9_halted", if16.halted, 1);
        check("x16_pc", if16.pc_out, 12);
        check("x16_count", if16.retired_count, 3);
        check("x16_x0", if16.register_check[0], 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
